zbb_issue_stage: RTL and testbench
==================================

ZBB_ISSUE_STAGE -- requirements
Module: zbb_issue_stage

Interface
REQ-001 SHALL have parameter ILLEGAL_CODE, default 5'b00000, the instr_o code emitted for any undecoded word.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid_i, input, 1, upstream word valid.
REQ-005 SHALL have port in_ready_o, output, 1, stage can accept a word.
REQ-006 SHALL have port instr_word_i, input, 32, raw RV32 instruction.
REQ-007 SHALL have ports rs1_data_i and rs2_data_i, input, 32 each, register-file read data.
REQ-008 SHALL have port out_valid_o, output, 1, issued op valid toward the Zbb ALU.
REQ-009 SHALL have port out_ready_i, input, 1, ALU side accepts the op.
REQ-010 SHALL have ports instr_word_o (32), operand1_o (32), operand2_o (32), instr_o (5) and illegal_o (1), all outputs, forming the ALU operand bundle.

Function
REQ-011 SHALL transfer on the input side when in_valid_i&&in_ready_o and on the output side when out_valid_o&&out_ready_i, both at the clock edge.
REQ-012 SHALL register the decoded bundle: one-cycle latency from input transfer to out_valid_o when the output register is empty or draining.
REQ-013 SHALL contain a main output register and a one-entry skid register; in_ready_o SHALL be registered and equal to "skid empty".
REQ-014 SHALL capture an input into the skid only when the main register is valid and out_ready_i=0 at the transfer edge; the next output transfer SHALL move skid to main.
REQ-015 SHALL never drop, duplicate or reorder words; on a simultaneous input and output transfer, the new word SHALL take the main register (or queue behind skid).
REQ-016 SHALL hold all outputs stable while out_valid_o=1 and out_ready_i=0.
REQ-017 SHALL decode into instr_o: clz 00001, ctz 00010, minu 00100, maxu 00101, sext.h 00110, sext.b 00111, max 01000, min 01001, zext.h 01010, rol 01011, ror 01100, rori 01101, orc.b 01110, rev8 01111, cpop 10000.
REQ-018 SHALL use these encodings: OP-IMM 0010011 with funct7 0110000/funct3 001 and rs2 00000/00001/00010/00100/00101 for clz/ctz/cpop/sext.b/sext.h; funct3 101 with funct7 0110000 for rori; imm 0x287 for orc.b; imm 0x698 for rev8.
REQ-019 SHALL use these OP 0110011 encodings: funct7 0000101 with funct3 100/101/110/111 for min/minu/max/maxu; funct7 0000100, funct3 100, rs2 0 for zext.h; funct7 0110000 with funct3 001/101 for rol/ror.
REQ-020 SHALL drive operand1_o=rs1_data_i, and operand2_o=rs2_data_i for OP-format words or {27'b0,instr_word_i[24:20]} for OP-IMM words.
REQ-021 SHALL pass instr_word_i through unchanged to instr_word_o.
REQ-022 SHALL, for any other word, issue it normally with instr_o=ILLEGAL_CODE and illegal_o=1; illegal words SHALL NOT stall the stage.

Reset
REQ-023 SHALL, on rst_ni=0, immediately clear out_valid_o, the skid valid, illegal_o, instr_o (to ILLEGAL_CODE) and all data outputs to 0, and SHALL drive in_ready_o=1.
REQ-024 SHALL discard buffered words on reset mid-operation; the first accept SHALL be possible on the first edge after rst_ni rises.

Configuration
REQ-025 SHALL decode rol, ror and rori per REQ-017 when ZBB_ROTATE_EN is defined; without the macro these words SHALL be treated as illegal per REQ-022.

Verification
REQ-026 SHALL pass: minu word (0x0A20D0B3), rs1=5, rs2=9, out_ready_i=1 -> next cycle out_valid_o=1, instr_o=00100, operand1_o=5, operand2_o=9, illegal_o=0.
REQ-027 SHALL pass: rori word 0x6050D093 with macro defined -> instr_o=01101, operand2_o=5; with the macro undefined -> instr_o=ILLEGAL_CODE, illegal_o=1.
REQ-028 SHALL pass: three back-to-back words with out_ready_i held 0 -> two accepted, in_ready_o=0 on the third; release out_ready_i -> all emitted in order, no loss.
REQ-029 SHALL pass: random valid/ready toggling over 1000 words -> output sequence equals input sequence exactly.
REQ-030 SHALL pass: rst_ni pulsed low while both registers are full -> out_valid_o=0 and in_ready_o=1 asynchronously, with no stale word emitted after reset.
REQ-031 SHALL pass: word 0xFFFFFFFF -> instr_o=ILLEGAL_CODE, illegal_o=1, issued with one-cycle latency.

Source files
------------

// File: rtl/zbb_issue_stage.sv
// Zbb issue stage: decodes RV32 Zbb words into ALU operand bundles behind a main register and a one-entry skid.
// Build option: define ZBB_ROTATE_EN to decode rol/ror/rori; otherwise those words issue as illegal.
module zbb_issue_stage #(
  parameter logic [4:0] ILLEGAL_CODE = 5'b00000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_word_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_word_o,
  output logic [31:0] operand1_o,
  output logic [31:0] operand2_o,
  output logic [4:0]  instr_o,
  output logic        illegal_o
);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ZBB     = 7'b0110000;
  localparam logic [6:0] F7_MINMAX  = 7'b0000101;
  localparam logic [6:0] F7_ZEXT    = 7'b0000100;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  code;
    logic        illegal;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '{word: 32'd0, op1: 32'd0, op2: 32'd0,
                                     code: ILLEGAL_CODE, illegal: 1'b0};

  function automatic bundle_t decode_word(input logic [31:0] w,
                                          input logic [31:0] r1,
                                          input logic [31:0] r2);
    bundle_t    b;
    logic       hit;
    logic [4:0] code;
    hit  = 1'b0;
    code = 5'b00000;
    case (w[6:0])
      OPC_OP_IMM: begin
        case (w[14:12])
          3'b001: begin
            case ({w[31:25], w[24:20]})
              {F7_ZBB, 5'b00000}: begin hit = 1'b1; code = 5'b00001; end
              {F7_ZBB, 5'b00001}: begin hit = 1'b1; code = 5'b00010; end
              {F7_ZBB, 5'b00010}: begin hit = 1'b1; code = 5'b10000; end
              {F7_ZBB, 5'b00100}: begin hit = 1'b1; code = 5'b00111; end
              {F7_ZBB, 5'b00101}: begin hit = 1'b1; code = 5'b00110; end
              default:            hit = 1'b0;
            endcase
          end
          3'b101: begin
            // orc.b and rev8 are fixed immediates; anything else in this slot can only be rori
            case (w[31:20])
              12'h287: begin hit = 1'b1; code = 5'b01110; end
              12'h698: begin hit = 1'b1; code = 5'b01111; end
              default: begin
`ifdef ZBB_ROTATE_EN
                case (w[31:25])
                  F7_ZBB:  begin hit = 1'b1; code = 5'b01101; end
                  default: hit = 1'b0;
                endcase
`else
                hit = 1'b0;
`endif
              end
            endcase
          end
          default: hit = 1'b0;
        endcase
      end
      OPC_OP: begin
        case ({w[31:25], w[14:12]})
          {F7_MINMAX, 3'b100}: begin hit = 1'b1; code = 5'b01001; end
          {F7_MINMAX, 3'b101}: begin hit = 1'b1; code = 5'b00100; end
          {F7_MINMAX, 3'b110}: begin hit = 1'b1; code = 5'b01000; end
          {F7_MINMAX, 3'b111}: begin hit = 1'b1; code = 5'b00101; end
          {F7_ZEXT, 3'b100}: begin
            case (w[24:20])
              5'b00000: begin hit = 1'b1; code = 5'b01010; end
              default:  hit = 1'b0;
            endcase
          end
`ifdef ZBB_ROTATE_EN
          {F7_ZBB, 3'b001}: begin hit = 1'b1; code = 5'b01011; end
          {F7_ZBB, 3'b101}: begin hit = 1'b1; code = 5'b01100; end
`endif
          default: hit = 1'b0;
        endcase
      end
      default: hit = 1'b0;
    endcase
    b.word    = w;
    b.op1     = r1;
    b.op2     = (w[6:0] == OPC_OP_IMM) ? {27'd0, w[24:20]} : r2;
    b.code    = hit ? code : ILLEGAL_CODE;
    b.illegal = ~hit;
    return b;
  endfunction

  bundle_t main_r;
  bundle_t skid_r;
  logic    main_valid_r;
  logic    skid_valid_r;
  logic    in_ready_r;

  bundle_t dec_s;
  bundle_t main_nxt_s;
  bundle_t skid_nxt_s;
  logic    main_valid_nxt_s;
  logic    skid_valid_nxt_s;
  logic    in_xfer_s;
  logic    out_xfer_s;

  assign dec_s      = decode_word(instr_word_i, rs1_data_i, rs2_data_i);
  assign in_xfer_s  = in_valid_i & in_ready_r;
  assign out_xfer_s = main_valid_r & out_ready_i;

  // Next-state for main/skid: refill main from skid first so ordering is preserved
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (!main_valid_r || out_xfer_s) begin
      if (skid_valid_r) begin
        main_nxt_s       = skid_r;
        main_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else if (in_xfer_s) begin
        main_nxt_s       = dec_s;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else begin
      if (in_xfer_s) begin
        skid_nxt_s       = dec_s;
        skid_valid_nxt_s = 1'b1;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
    end
  end

  // Pipeline state registers; in_ready is registered as "skid will be empty"
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_r       <= BUNDLE_RST;
      skid_r       <= BUNDLE_RST;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
    end
  end

  assign in_ready_o   = in_ready_r;
  assign out_valid_o  = main_valid_r;
  assign instr_word_o = main_r.word;
  assign operand1_o   = main_r.op1;
  assign operand2_o   = main_r.op2;
  assign instr_o      = main_r.code;
  assign illegal_o    = main_r.illegal;

endmodule

// File: tb/tb_zbb_issue_stage.sv
// Self-checking bench for zbb_issue_stage: directed scenarios plus a randomized scoreboard run.
// Expected bundles come from a mask/match instruction table model; ZBB_ROTATE_EN selects rotate expectations.
module tb_zbb_issue_stage;
  localparam logic [4:0] ILL = 5'b00000;
`ifdef ZBB_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_word_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_word_o;
  logic [31:0] operand1_o;
  logic [31:0] operand2_o;
  logic [4:0]  instr_o;
  logic        illegal_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  code;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  code;
    logic        rot;
  } entry_t;

  zbb_issue_stage #(.ILLEGAL_CODE(ILL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_word_i(instr_word_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_word_o(instr_word_o), .operand1_o(operand1_o), .operand2_o(operand2_o),
    .instr_o(instr_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Zbb instruction table as mask/match pairs
  function automatic entry_t tbl(input int i);
    entry_t e;
    e.rot = 1'b0;
    case (i)
      0:  begin e.mask = 32'hFFF0707F; e.match = 32'h60001013; e.code = 5'd1;  end // clz
      1:  begin e.mask = 32'hFFF0707F; e.match = 32'h60101013; e.code = 5'd2;  end // ctz
      2:  begin e.mask = 32'hFFF0707F; e.match = 32'h60201013; e.code = 5'd16; end // cpop
      3:  begin e.mask = 32'hFFF0707F; e.match = 32'h60401013; e.code = 5'd7;  end // sext.b
      4:  begin e.mask = 32'hFFF0707F; e.match = 32'h60501013; e.code = 5'd6;  end // sext.h
      5:  begin e.mask = 32'hFFF0707F; e.match = 32'h28705013; e.code = 5'd14; end // orc.b
      6:  begin e.mask = 32'hFFF0707F; e.match = 32'h69805013; e.code = 5'd15; end // rev8
      7:  begin e.mask = 32'hFE00707F; e.match = 32'h0A004033; e.code = 5'd9;  end // min
      8:  begin e.mask = 32'hFE00707F; e.match = 32'h0A005033; e.code = 5'd4;  end // minu
      9:  begin e.mask = 32'hFE00707F; e.match = 32'h0A006033; e.code = 5'd8;  end // max
      10: begin e.mask = 32'hFE00707F; e.match = 32'h0A007033; e.code = 5'd5;  end // maxu
      11: begin e.mask = 32'hFFF0707F; e.match = 32'h08004033; e.code = 5'd10; end // zext.h
      12: begin e.mask = 32'hFE00707F; e.match = 32'h60005013; e.code = 5'd13; e.rot = 1'b1; end // rori
      13: begin e.mask = 32'hFE00707F; e.match = 32'h60001033; e.code = 5'd11; e.rot = 1'b1; end // rol
      default: begin e.mask = 32'hFE00707F; e.match = 32'h60005033; e.code = 5'd12; e.rot = 1'b1; end // ror
    endcase
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
    exp_t   e;
    entry_t t;
    e.word = w;
    e.op1  = r1;
    e.op2  = (w[6:0] == 7'h13) ? {27'd0, w[24:20]} : r2;
    e.code = ILL;
    e.ill  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      t = tbl(i);
      if (((w & t.mask) == t.match) && (!t.rot || ROT)) begin
        e.code = t.code;
        e.ill  = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_word();
    entry_t t;
    if ($urandom_range(0, 3) == 0) return $urandom;
    t = tbl(int'($urandom_range(0, 14)));
    return t.match | ($urandom & ~t.mask);
  endfunction

  task automatic test_reset();
    exp_t obs;
    repeat (2) @(negedge clk_i);
    obs = {instr_word_o, operand1_o, operand2_o, instr_o, illegal_o};
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
    checks++; if (obs !== {96'd0, ILL, 1'b0}) begin errors++; $display("FAIL reset_bundle: got %h expected %h", obs, {96'd0, ILL, 1'b0}); end
    rst_ni = 1'b1;
  endtask

  task automatic test_minu();
    in_valid_i = 1'b1; instr_word_i = 32'h0A20D0B3; rs1_data_i = 32'd5; rs2_data_i = 32'd9; out_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL minu_valid: got %b expected 1", out_valid_o); end
    checks++; if (instr_o !== 5'b00100) begin errors++; $display("FAIL minu_code: got %b expected 00100", instr_o); end
    checks++; if (operand1_o !== 32'd5 || operand2_o !== 32'd9) begin errors++; $display("FAIL minu_operands: got %0d,%0d expected 5,9", operand1_o, operand2_o); end
    checks++; if (illegal_o !== 1'b0 || instr_word_o !== 32'h0A20D0B3) begin errors++; $display("FAIL minu_word: got %b/%h expected 0/0a20d0b3", illegal_o, instr_word_o); end
    @(posedge clk_i); @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL minu_drain: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_rori();
    in_valid_i = 1'b1; instr_word_i = 32'h6050D093; rs1_data_i = $urandom; rs2_data_i = $urandom; out_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rori_valid: got %b expected 1", out_valid_o); end
    checks++; if (instr_o !== (ROT ? 5'b01101 : ILL) || illegal_o !== !ROT) begin
      errors++; $display("FAIL rori_code: got %b/%b expected %b/%b", instr_o, illegal_o, ROT ? 5'b01101 : ILL, !ROT); end
    checks++; if (operand2_o !== 32'd5) begin errors++; $display("FAIL rori_op2: got %0d expected 5", operand2_o); end
    @(posedge clk_i); @(negedge clk_i);
  endtask

  task automatic test_illegal();
    logic [31:0] r2;
    r2 = $urandom;
    in_valid_i = 1'b1; instr_word_i = 32'hFFFFFFFF; rs1_data_i = $urandom; rs2_data_i = r2; out_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL illegal_latency: got %b expected 1", out_valid_o); end
    checks++; if (instr_o !== ILL || illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_code: got %b/%b expected %b/1", instr_o, illegal_o, ILL); end
    checks++; if (operand2_o !== r2) begin errors++; $display("FAIL illegal_op2: got %h expected %h", operand2_o, r2); end
    @(posedge clk_i); @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        obs;
    exp_t        e;
    logic [31:0] w[3];
    logic [31:0] r1[3];
    logic [31:0] r2[3];
    int          idx = 0;
    int          got = 0;
    for (int i = 0; i < 3; i++) begin w[i] = gen_word(); r1[i] = $urandom; r2[i] = $urandom; end
    out_ready_i = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      in_valid_i = 1'b1; instr_word_i = w[cyc]; rs1_data_i = r1[cyc]; rs2_data_i = r2[cyc];
      checks++; if (in_ready_o !== (cyc < 2)) begin errors++; $display("FAIL b2b_in_ready%0d: got %b expected %b", cyc, in_ready_o, cyc < 2); end
      if (in_ready_o) begin q.push_back(model(w[cyc], r1[cyc], r2[cyc])); idx++; end
      @(posedge clk_i); @(negedge clk_i);
    end
    checks++; if (out_valid_o !== 1'b1 || instr_word_o !== w[0]) begin errors++; $display("FAIL b2b_hold: got %b/%h expected 1/%h", out_valid_o, instr_word_o, w[0]); end
    out_ready_i = 1'b1;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      in_valid_i = (idx < 3);
      if (idx < 3) begin instr_word_i = w[idx]; rs1_data_i = r1[idx]; rs2_data_i = r2[idx]; end
      else begin instr_word_i = $urandom; end
      if (out_valid_o) begin
        obs = {instr_word_o, operand1_o, operand2_o, instr_o, illegal_o};
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra: got %h expected none", obs); end
        else begin e = q.pop_front(); if (obs !== e) begin errors++; $display("FAIL b2b_order: got %h expected %h", obs, e); end end
        got++;
      end
      if (in_valid_i && in_ready_o) begin q.push_back(model(w[idx], r1[idx], r2[idx])); idx++; end
      @(posedge clk_i); @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", got); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t obs;
    exp_t hold;
    exp_t e;
    bit   stalled = 1'b0;
    int   sent = 0;
    int   recv = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() > 0 || out_valid_o); cyc++) begin
      obs = {instr_word_o, operand1_o, operand2_o, instr_o, illegal_o};
      if (stalled) begin
        checks++;
        if (obs !== hold || out_valid_o !== 1'b1) begin errors++; $display("FAIL rand_stable: got %h expected %h", obs, hold); end
      end
      in_valid_i   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      instr_word_i = gen_word();
      rs1_data_i   = $urandom;
      rs2_data_i   = $urandom;
      out_ready_i  = ($urandom_range(0, 2) != 0);
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand_extra: got %h expected none", obs); end
        else begin e = q.pop_front(); if (obs !== e) begin errors++; $display("FAIL rand_seq%0d: got %h expected %h", recv, obs, e); end end
        recv++;
      end
      if (in_valid_i && in_ready_o) begin q.push_back(model(instr_word_i, rs1_data_i, rs2_data_i)); sent++; end
      stalled = out_valid_o && !out_ready_i;
      hold    = obs;
      @(posedge clk_i); @(negedge clk_i);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    checks++; if (recv != 1000 || q.size() != 0) begin errors++; $display("FAIL rand_total: got %0d words (%0d left) expected 1000", recv, q.size()); end
  endtask

  task automatic test_reset_mid();
    exp_t        obs;
    exp_t        e;
    logic [31:0] w;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_word_i = gen_word(); rs1_data_i = $urandom; rs2_data_i = $urandom;
      @(posedge clk_i); @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    checks++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_full: got %b/%b expected 0/1", in_ready_o, out_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready_o); end
    checks++; if (instr_o !== ILL || illegal_o !== 1'b0 || instr_word_o !== 32'd0) begin errors++; $display("FAIL rstmid_bundle: got %b/%b/%h expected %b/0/0", instr_o, illegal_o, instr_word_o, ILL); end
    @(negedge clk_i);
    rst_ni = 1'b1; out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); @(negedge clk_i);
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d: got %b expected 0", i, out_valid_o); end
    end
    w = gen_word();
    in_valid_i = 1'b1; instr_word_i = w; rs1_data_i = $urandom; rs2_data_i = $urandom;
    e = model(w, rs1_data_i, rs2_data_i);
    @(posedge clk_i); @(negedge clk_i);
    in_valid_i = 1'b0;
    obs = {instr_word_o, operand1_o, operand2_o, instr_o, illegal_o};
    checks++; if (out_valid_o !== 1'b1 || obs !== e) begin errors++; $display("FAIL rstmid_fresh: got %b/%h expected 1/%h", out_valid_o, obs, e); end
    @(posedge clk_i); @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    instr_word_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    test_reset();
    test_minu();
    test_rori();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
